// File: rtl/mode_sequencer_if.sv
// Operator/agent-facing bundle of the mode sequencer: raw controls in, phase and mode selects out.
// The slave modport is the sequencer's view; master is the view of whoever drives the controls.
interface mode_sequencer_if #(
    parameter int NUM_PHASES = 3,
    parameter int IDX_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
);
    logic                  next;
    logic [NUM_PHASES-1:0] phase_done;
    logic                  abort;
    logic [NUM_PHASES-1:0] phase_active;
    logic [IDX_W-1:0]      phase_idx;
    logic                  run;
    logic                  error;
    logic                  step;

    modport master (
        output next, phase_done, abort,
        input  phase_active, phase_idx, run, error, step
    );

    modport slave (
        input  next, phase_done, abort,
        output phase_active, phase_idx, run, error, step
    );
endinterface

// File: rtl/mode_sequencer.sv
// Boot/load/run controller: walks the CPU through NUM_PHASES load phases gated by a debounced
// operator button and per-phase done handshakes, with phase timeout, error state and abort.
module mode_sequencer #(
    parameter int NUM_PHASES      = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int IDX_W           = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    mode_sequencer_if.slave  bus
);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PHASES - 1);
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_PHASE = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   done_seen_q, done_seen_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   sync1_q, sync2_q;
    logic                   next_db_q, next_db_d;
    logic                   next_db_prev_q;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [NUM_PHASES-1:0]  phase_active_q, phase_active_d;
    logic [IDX_W-1:0]       phase_idx_q, phase_idx_d;
    logic                   run_q, run_d;
    logic                   error_q, error_d;
    logic                   step_q, step_d;
    logic                   adv_evt_s;
    logic                   done_now_s;
    logic                   timeout_s;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        next_db_d = next_db_q;
        db_cnt_d  = '0;
        if (sync2_q != next_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                next_db_d = sync2_q;
                db_cnt_d  = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    assign adv_evt_s = next_db_q & ~next_db_prev_q;

    // Input synchroniser and debounce state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            next_db_q      <= 1'b0;
            next_db_prev_q <= 1'b0;
            db_cnt_q       <= '0;
        end else begin
            sync1_q        <= bus.next;
            sync2_q        <= sync1_q;
            next_db_q      <= next_db_d;
            next_db_prev_q <= next_db_q;
            db_cnt_q       <= db_cnt_d;
        end
    end

    // Next-state logic: abort beats timeout beats advance everywhere except BOOT
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_seen_d = done_seen_q;
        tmr_d       = tmr_q;
        step_d      = 1'b0;
        done_now_s  = done_seen_q | bus.phase_done[idx_q];
        timeout_s   = TO_EN & (tmr_q == TMR_LAST) & ~done_now_s;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            ST_IDLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (adv_evt_s) begin
                    state_d     = ST_PHASE;
                    idx_d       = '0;
                    done_seen_d = 1'b0;
                    tmr_d       = '0;
                    step_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PHASE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (timeout_s) begin
                    state_d = ST_ERROR;
                    idx_d   = '0;
                end else if (adv_evt_s && done_now_s) begin
                    step_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        done_seen_d = 1'b0;
                        tmr_d       = '0;
                    end
                end else begin
                    done_seen_d = done_now_s;
                    if (tmr_q != TMR_LAST) begin
                        tmr_d = tmr_q + 1'b1;
                    end else begin
                        tmr_d = tmr_q;
                    end
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_BOOT;
                idx_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs change on the same edge as the state
    always_comb begin
        phase_active_d = '0;
        phase_idx_d    = '0;
        run_d          = (state_d == ST_RUN);
        error_d        = (state_d == ST_ERROR);
        if (state_d == ST_PHASE) begin
            phase_active_d = NUM_PHASES'(1'b1) << idx_d;
            phase_idx_d    = idx_d;
        end else begin
            phase_active_d = '0;
            phase_idx_d    = '0;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_BOOT;
            idx_q          <= '0;
            done_seen_q    <= 1'b0;
            tmr_q          <= '0;
            phase_active_q <= '0;
            phase_idx_q    <= '0;
            run_q          <= 1'b0;
            error_q        <= 1'b0;
            step_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            done_seen_q    <= done_seen_d;
            tmr_q          <= tmr_d;
            phase_active_q <= phase_active_d;
            phase_idx_q    <= phase_idx_d;
            run_q          <= run_d;
            error_q        <= error_d;
            step_q         <= step_d;
        end
    end

    assign bus.phase_active = phase_active_q;
    assign bus.phase_idx    = phase_idx_q;
    assign bus.run          = run_q;
    assign bus.error        = error_q;
    assign bus.step         = step_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios plus random button/done/abort traffic, all outputs
// compared every cycle against an event-level model of the phase walk.
module tb_mode_sequencer;
    localparam int NP = 3;
    localparam int DB = 4;
    localparam int TO = 16;
    localparam int IW = 2;
    localparam int M_BOOT = -2;
    localparam int M_IDLE = -1;
    localparam int M_RUN  = 100;
    localparam int M_ERR  = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          drv_rst   = 1'b0;
    logic          drv_next  = 1'b0;
    logic          drv_abort = 1'b0;
    logic [NP-1:0] drv_done  = '0;

    mode_sequencer_if #(.NUM_PHASES(NP), .IDX_W(IW)) bus ();
    mode_sequencer_if #(.NUM_PHASES(NP), .IDX_W(IW)) bus0 ();

    assign bus.next        = drv_next;
    assign bus.phase_done  = drv_done;
    assign bus.abort       = drv_abort;
    assign bus0.next       = drv_next;
    assign bus0.phase_done = '0;
    assign bus0.abort      = 1'b0;

    mode_sequencer #(.NUM_PHASES(NP), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (drv_rst),
        .bus (bus)
    );

    mode_sequencer #(.NUM_PHASES(NP), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(0), .IDX_W(IW)) dut_to0 (
        .clk (clk),
        .rst (drv_rst),
        .bus (bus0)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n;
    bit step_seen = 1'b0;
    bit ever_err0 = 1'b0;

    // Reference model: mode is BOOT/IDLE/phase number/RUN/ERR; phase age is derived from edge numbers
    bit [1:0] m_pipe;
    bit       m_level;
    int       m_streak;
    bit       m_rose;
    int       m_mode;
    int       m_edge;
    int       m_entry;
    bit       m_done;
    bit       m_step;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus.phase_active, bus.phase_idx, bus.run, bus.error, bus.step});
    endfunction

    function automatic logic [31:0] model_vec();
        logic [NP-1:0] pa;
        logic [IW-1:0] ix;
        pa = '0;
        ix = '0;
        if (m_mode >= 0 && m_mode < NP) begin
            pa[m_mode] = 1'b1;
            ix = IW'(m_mode);
        end
        return 32'({pa, ix, (m_mode == M_RUN), (m_mode == M_ERR), m_step});
    endfunction

    task automatic model_reset();
        m_pipe = 2'b00; m_level = 1'b0; m_streak = 0; m_rose = 1'b0;
        m_mode = M_BOOT; m_edge = 0; m_entry = 0; m_done = 1'b0; m_step = 1'b0;
    endtask

    task automatic model_edge();
        bit sync, adv, acc, done_now;
        int nmode;
        if (!drv_rst) return;
        m_edge++;
        adv    = m_rose;
        sync   = m_pipe[1];
        m_pipe = {m_pipe[0], drv_next};
        m_rose = 1'b0;
        if (sync != m_level) begin
            m_streak++;
            if (m_streak == DB) begin
                m_level  = sync;
                m_streak = 0;
                m_rose   = sync;
            end
        end else begin
            m_streak = 0;
        end
        acc   = 1'b0;
        nmode = m_mode;
        if (m_mode == M_BOOT) nmode = M_IDLE;
        else if (drv_abort) nmode = M_IDLE;
        else if (m_mode == M_IDLE) begin
            if (adv) begin nmode = 0; acc = 1'b1; end
        end else if (m_mode >= 0 && m_mode < NP) begin
            done_now = m_done || drv_done[m_mode];
            if (TO != 0 && (m_edge - m_entry) >= TO && !done_now) nmode = M_ERR;
            else if (adv && done_now) begin
                nmode = (m_mode + 1 == NP) ? M_RUN : m_mode + 1;
                acc = 1'b1;
            end
            if (drv_done[m_mode]) m_done = 1'b1;
        end
        if (acc && nmode >= 0 && nmode < NP) begin
            m_entry = m_edge;
            m_done  = 1'b0;
        end
        m_mode = nmode;
        m_step = acc;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("cycle", out_vec(), model_vec());
        if (bus.step) step_seen = 1'b1;
        if (bus0.error) ever_err0 = 1'b1;
    endtask

    task automatic do_reset();
        drv_rst = 1'b0; drv_next = 1'b0; drv_done = '0; drv_abort = 1'b0;
        #1;
        model_reset();
        check_eq("rst_out", out_vec(), 32'd0);
        repeat (2) cyc();
        drv_rst = 1'b1;
    endtask

    task automatic press_measure(output int cnt);
        cnt = 0;
        drv_next = 1'b1;
        do begin
            cyc();
            cnt++;
        end while (!bus.step && cnt < 20);
        drv_next = 1'b0;
    endtask

    task automatic settle();
        repeat (7) cyc();
    endtask

    task automatic pulse_done(input logic [NP-1:0] d);
        drv_done = d;
        cyc();
        drv_done = '0;
    endtask

    initial begin
        do_reset();
        step_seen = 1'b0;
        repeat (4) cyc();
        check_eq("boot_no_step", 32'(step_seen), 32'd0);
        check_eq("boot_idle_out", out_vec(), 32'd0);

        // 3-cycle glitch must not advance
        drv_next = 1'b1;
        repeat (3) cyc();
        drv_next = 1'b0;
        repeat (10) cyc();
        check_eq("glitch_step", 32'(step_seen), 32'd0);
        check_eq("glitch_pa", 32'(bus.phase_active), 32'd0);

        // Full walk through all phases into RUN
        press_measure(n);
        check_eq("lat_p0", 32'(n), 32'd7);
        check_eq("pa_p0", 32'(bus.phase_active), 32'd1);
        pulse_done(3'b001);
        settle();
        press_measure(n);
        check_eq("lat_p1", 32'(n), 32'd7);
        check_eq("pa_p1", 32'(bus.phase_active), 32'd2);
        settle();
        step_seen = 1'b0;
        drv_next = 1'b1;
        repeat (7) cyc();
        drv_next = 1'b0;
        check_eq("nodone_step", 32'(step_seen), 32'd0);
        check_eq("nodone_pa", 32'(bus.phase_active), 32'd2);
        pulse_done(3'b010);
        settle();
        press_measure(n);
        check_eq("lat_p2", 32'(n), 32'd7);
        check_eq("pa_p2", 32'(bus.phase_active), 32'd4);
        check_eq("idx_p2", 32'(bus.phase_idx), 32'd2);
        pulse_done(3'b100);
        settle();
        press_measure(n);
        check_eq("lat_run", 32'(n), 32'd7);
        check_eq("run", 32'(bus.run), 32'd1);
        check_eq("run_pa", 32'(bus.phase_active), 32'd0);
        settle();
        drv_abort = 1'b1;
        cyc();
        drv_abort = 1'b0;
        check_eq("abort_run", out_vec(), 32'd0);
        settle();

        // Timeout into ERROR, press ignored, abort recovers
        press_measure(n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.error && n < 40);
        check_eq("to_cycles", 32'(n), 32'd16);
        settle();
        step_seen = 1'b0;
        drv_next = 1'b1;
        repeat (9) cyc();
        drv_next = 1'b0;
        settle();
        check_eq("err_press", 32'(bus.error), 32'd1);
        check_eq("err_no_step", 32'(step_seen), 32'd0);
        drv_abort = 1'b1;
        cyc();
        drv_abort = 1'b0;
        check_eq("err_abort", out_vec(), 32'd0);
        settle();

        // Done on the last cycle before timeout wins
        press_measure(n);
        repeat (15) cyc();
        pulse_done(3'b001);
        check_eq("to_edge_err", 32'(bus.error), 32'd0);
        check_eq("to_edge_pa", 32'(bus.phase_active), 32'd1);
        repeat (20) cyc();
        check_eq("to_edge_later", 32'(bus.error), 32'd0);
        press_measure(n);
        check_eq("to_edge_adv", 32'(bus.phase_active), 32'd2);

        // Abort coincident with adv_evt in PHASE 1, then held next must not retrigger
        settle();
        drv_next = 1'b1;
        repeat (6) cyc();
        drv_abort = 1'b1;
        cyc();
        drv_abort = 1'b0;
        check_eq("abort_adv", out_vec(), 32'd0);
        step_seen = 1'b0;
        repeat (12) cyc();
        check_eq("held_no_retrig", 32'(step_seen), 32'd0);
        check_eq("held_idle", out_vec(), 32'd0);
        drv_next = 1'b0;
        settle();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) drv_next = ~drv_next;
            drv_done  = ($urandom_range(0, 3) == 0) ? NP'($urandom_range(0, (1 << NP) - 1)) : '0;
            drv_abort = ($urandom_range(0, 39) == 0);
            cyc();
        end
        drv_abort = 1'b0;
        drv_done  = '0;

        // Asynchronous reset in the middle of PHASE 2
        do_reset();
        cyc();
        press_measure(n);
        pulse_done(3'b001);
        settle();
        press_measure(n);
        pulse_done(3'b010);
        settle();
        press_measure(n);
        check_eq("pre_rst_pa", 32'(bus.phase_active), 32'd4);
        cyc();
        #2;
        drv_rst = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst", out_vec(), 32'd0);
        repeat (2) cyc();
        drv_rst = 1'b1;
        settle();

        // Timeout disabled instance: parked in PHASE 0 without done
        press_measure(n);
        ever_err0 = 1'b0;
        repeat (1000) cyc();
        check_eq("to0_err", 32'(ever_err0), 32'd0);
        check_eq("to0_pa", 32'(bus0.phase_active), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
